// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter
//   Interrupt source side of the CP0 interrupt interface. Three raw external
//   lines are synchronised and their rising edges are latched as pending
//   events. Pending events that pass the CP0 mask, the global disable and
//   the in-service nesting rule compete by fixed priority (2 > 1 > 0). The
//   winner is presented as a stable one-hot request plus its entrance vector
//   until the CPU acknowledges it or it becomes ineligible.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   irq_in       raw asynchronous interrupt lines (event = rising edge)
//   irq_mask     CP0 mask, 1 = source enabled
//   irq_disable  CP0 global disable, 1 = no new request issued
//   irq_ack      1-cycle pulse: CPU took the presented interrupt
//   irq_eret     1-cycle pulse: CPU executed exception return
//   irq_req      one-hot granted request (registered)
//   irq_active   OR of irq_req (registered)
//   irq_vector   entrance address of the granted source, 0 when none
//   in_service   sources currently being serviced
module interrupt_arbiter #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VEC0        = 32'h0000_0800,
  parameter logic [31:0] VEC1        = 32'h0000_0600,
  parameter logic [31:0] VEC2        = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  irq_in,
  input  logic [2:0]  irq_mask,
  input  logic        irq_disable,
  input  logic        irq_ack,
  input  logic        irq_eret,
  output logic [2:0]  irq_req,
  output logic        irq_active,
  output logic [31:0] irq_vector,
  output logic [2:0]  in_service
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]  sync_lvl;
  logic [2:0]  edge_hist;
  logic [2:0]  rise;
  logic [2:0]  pending;
  logic [2:0]  pend_clr;
  logic [2:0]  ins_set;
  logic [2:0]  allowed;
  logic [2:0]  eligible;
  logic [2:0]  pick;
  logic [2:0]  eret_clr;
  logic [2:0]  req_d;
  logic [31:0] vec_d;

  function automatic logic [31:0] vec_of(input logic [2:0] oh);
    logic [31:0] v;
    v = '0;
    if (oh[2])      v = VEC2;
    else if (oh[1]) v = VEC1;
    else if (oh[0]) v = VEC0;
    return v;
  endfunction

  // Synchroniser and edge detection
  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~edge_hist;

  // Only sources strictly above the highest in-service level may preempt.
  always_comb begin
    if (in_service[2])      allowed = 3'b000;
    else if (in_service[1]) allowed = 3'b100;
    else if (in_service[0]) allowed = 3'b110;
    else                    allowed = 3'b111;
  end

  assign eligible = pending & irq_mask & {3{~irq_disable}} & allowed;

  always_comb begin
    if (eligible[2])      pick = 3'b100;
    else if (eligible[1]) pick = 3'b010;
    else if (eligible[0]) pick = 3'b001;
    else                  pick = 3'b000;
  end

  // eret retires the innermost (highest) level that is in service.
  always_comb begin
    if (in_service[2])      eret_clr = 3'b100;
    else if (in_service[1]) eret_clr = 3'b010;
    else if (in_service[0]) eret_clr = 3'b001;
    else                    eret_clr = 3'b000;
  end

  // Grant FSM: next state and next registered outputs
  always_comb begin
    state_d  = state_q;
    req_d    = irq_req;
    vec_d    = irq_vector;
    pend_clr = '0;
    ins_set  = '0;
    case (state_q)
      IDLE: begin
        req_d = '0;
        vec_d = '0;
        if (|pick) begin
          state_d = REQ;
          req_d   = pick;
          vec_d   = vec_of(pick);
        end
      end
      REQ: begin
        // Ack wins over withdrawal when both happen in one cycle.
        if (irq_ack) begin
          pend_clr = irq_req;
          ins_set  = irq_req;
          state_d  = IDLE;
          req_d    = '0;
          vec_d    = '0;
        end else if ((eligible & irq_req) == 3'b000) begin
          state_d = IDLE;
          req_d   = '0;
          vec_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = '0;
        vec_d   = '0;
      end
    endcase
  end

  // Registered state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      edge_hist  <= '0;
      pending    <= '0;
      in_service <= '0;
      irq_req    <= '0;
      irq_active <= 1'b0;
      irq_vector <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], irq_in};
      edge_hist  <= sync_lvl;
      // A fresh edge on the source being acked re-arms it.
      pending    <= (pending & ~pend_clr) | rise;
      // eret acts on the pre-update value, then the ack sets its level.
      in_service <= (in_service & ~(irq_eret ? eret_clr : 3'b000)) | ins_set;
      irq_req    <= req_d;
      irq_active <= |req_d;
      irq_vector <= vec_d;
    end
  end

endmodule

// File: doc/interrupt_arbiter.md
Name: interrupt_arbiter

Overview:
- Interrupt source side of the CPU's CP0 interrupt interface.
- Synchronises 3 raw external interrupt lines and latches their rising edges as pending events.
- Applies the CP0 mask and global-disable bits, then presents one prioritised, stable, one-hot request plus its entrance vector to the pipeline.
- Tracks in-service levels, driven by the CPU's take-interrupt acknowledge and exception-return (eret) pulses.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on each irq_in bit (≥2).
- VEC0, 32'h0000_0800: entrance address for source 0 (lowest priority).
- VEC1, 32'h0000_0600: entrance address for source 1.
- VEC2, 32'h0000_0400: entrance address for source 2 (highest priority).

Ports:
- clk  in  1  single system clock, posedge.
- rst  in  1  asynchronous, active-high reset.
- irq_in  in  3  raw asynchronous interrupt lines; event = rising edge.
- irq_mask  in  3  CP0 mask register (CP0 reg 0x17); 1 = source enabled.
- irq_disable  in  1  CP0 global disable (CP0 reg 0x16); 1 = no new request issued.
- irq_ack  in  1  one-cycle pulse: CPU took the presented interrupt (EPC captured).
- irq_eret  in  1  one-cycle pulse: CPU executed exception return.
- irq_req  out  3  one-hot granted request; all zero when none.
- irq_active  out  1  OR of irq_req.
- irq_vector  out  32  entrance address of the granted source; 0 when none.
- in_service  out  3  sources currently being serviced.

Behaviour:
- Reset is asynchronous. All of the following clear to 0: synchronisers, edge-history, pending, in_service, irq_req, irq_active, irq_vector. The FSM goes to IDLE.
- A reset asserted mid-request drops the request immediately and loses all pending events.
- Edge capture:
  - pending[i] is set at the clock edge where synchronised irq_in[i] is 1 and its previous sample is 0.
  - A level held high produces exactly one event.
  - A second edge on an already-pending source is merged (no counter).
- Latency: irq_in rising before edge E1 → pending set after edge E(SYNC_STAGES+1) → irq_req registered after edge E(SYNC_STAGES+2). With the default of 2 stages, that is 4 edges.
- Eligibility: source i is eligible when all of the following hold:
  - pending[i] is 1;
  - irq_mask[i] is 1;
  - irq_disable is 0;
  - i is above the highest set in_service bit (nested preemption by strictly higher priority only).
- Priority: bit 2 > bit 1 > bit 0.
- FSM states:
  - IDLE: irq_req = 0. If any source is eligible → REQ. The highest eligible source is latched into irq_req, and irq_vector is set to VECi.
  - REQ: irq_req and irq_vector are held stable, even if a higher-priority source becomes eligible.
    - irq_ack → pending[g] cleared, in_service[g] set, → IDLE (irq_req 0 next cycle).
    - Granted source becomes ineligible (mask cleared or irq_disable raised) without ack → withdraw to IDLE. pending[g] is kept.
    - Ack has priority over withdrawal in the same cycle.
- irq_ack while in IDLE is ignored.
- irq_eret clears the highest set in_service bit. It is ignored when in_service is 0.
- Simultaneous events:
  - irq_eret + irq_ack in the same cycle: eret clears its bit first (from the pre-update value), then ack sets the granted bit.
  - irq_ack + new edge on the granted source in the same cycle: pending stays 1 (new event wins).
- Minimum spacing: after ack, at least 1 IDLE cycle occurs before the next request.
- irq_active = |irq_req. Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then irq_in = 3'b001 with mask 3'b111 and disable 0 → irq_req = 001 and irq_vector = 0x800 after exactly 4 edges; held until ack. After ack: in_service = 001, irq_req = 0.
- irq_in 3'b011 rising in the same cycle → irq_req = 010, vector 0x600. Ack → next grant is not issued: source 0 is blocked while in_service = 010. irq_eret → irq_req = 001, vector 0x800.
- While REQ on source 0, source 2 edges → irq_req stays 001 until ack. Ack → in_service = 001, then source 2 is granted (0x400, preemption). Two erets → in_service goes 101 → 001 → 000.
- Mask = 3'b000, edge on source 1 → no request. Mask set to 010 → irq_req = 010 next edge. Raise irq_disable before ack → irq_req drops to 0, pending retained. Clear disable → request reissued.
- irq_in held high 20 cycles with one ack → exactly one request. Stray ack in IDLE and eret with in_service = 0 → no state change.
- Assert rst asynchronously mid-REQ → all outputs 0 immediately, no request after rst deasserts unless a new edge arrives.
